// File: rtl/muldiv_seq.sv
`default_nettype none
// muldiv_seq: multi-cycle shift-add multiply / restoring divide with persistent HI/LO results.
// Define MULDIV_SIGNED_EN to make ops 00/01 signed; otherwise they behave as unsigned 10/11.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo,
  output logic             oDivZero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, shreg, opnd, a_cap;
  logic             is_div, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] hi_fix, lo_fix;
  logic             start_ok;

  assign start_ok = (state == S_IDLE) && iStart;

`ifdef MULDIV_SIGNED_EN
  logic sgn_a, sgn_b, neg_main, neg_rem;

  always_comb begin
    sgn_a = ~iOp[1] & iA[WIDTH-1];
    sgn_b = ~iOp[1] & iB[WIDTH-1];
    a_mag = sgn_a ? -iA : iA;
    b_mag = sgn_b ? -iB : iB;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (start_ok) begin
      neg_main <= sgn_a ^ sgn_b;
      neg_rem  <= sgn_a;
    end
  end
`else
  logic unused_op_sign;
  assign unused_op_sign = iOp[1];

  always_comb begin
    a_mag = iA;
    b_mag = iB;
  end
`endif

  // State register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iStart) state_nxt = S_RUN;
      S_RUN:   if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    oBusy = (state != S_IDLE);
  end

  always_comb begin
    mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, shreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  // acc/shreg hold {hi,lo} of the product, or {remainder, dividend->quotient} for divide.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt      <= '0;
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      a_cap    <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else if (start_ok) begin
      cnt      <= CW'(WIDTH - 1);
      acc      <= '0;
      shreg    <= iOp[0] ? a_mag : b_mag;
      opnd     <= iOp[0] ? b_mag : a_mag;
      a_cap    <= iA;
      is_div   <= iOp[0];
      div_zero <= iOp[0] && (iB == '0);
    end else if (state == S_RUN) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (!is_div) begin
        acc   <= mul_sum[WIDTH:1];
        shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
        acc   <= div_diff[WIDTH-1:0];
        shreg <= {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc   <= div_shift[WIDTH-1:0];
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    hi_fix = acc;
    lo_fix = shreg;
    if (is_div && div_zero) begin
      hi_fix = a_cap;
      lo_fix = '1;
`ifdef MULDIV_SIGNED_EN
    end else if (!is_div) begin
      if (neg_main) {hi_fix, lo_fix} = -{acc, shreg};
    end else begin
      if (neg_rem)  hi_fix = -acc;
      if (neg_main) lo_fix = -shreg;
`endif
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oDone    <= 1'b0;
      oHi      <= '0;
      oLo      <= '0;
      oDivZero <= 1'b0;
    end else begin
      oDone <= (state == S_FIX);
      if (state == S_FIX) begin
        oHi      <= hi_fix;
        oLo      <= lo_fix;
        oDivZero <= div_zero;
      end
    end
  end
endmodule
`default_nettype wire
